universal_shift_reg: RTL and testbench

- Parametrised successor to the team's single-bit D storage element: a WIDTH-bit clocked universal shift register.
- Supports hold, shift right, shift left and parallel load, with serial in/out on both ends.
- Includes a saturating shift counter and a one-cycle DONE pulse once WIDTH shifts follow a load.
- Used as a serialiser/deserialiser building block in later assignments and datapaths.

---
 rtl/universal_shift_reg.sv | 97 +++++++++
 tb/tb_universal_shift_reg.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / load,
// saturating shift counter and DONE pulse. Define USR_ROTATE_EN to make ROT functional.
module universal_shift_reg #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   localparam int                CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic             sir_i,
   input  logic             sil_i,
   input  logic             rot_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             sor_o,
   output logic             sol_o,
   output logic [CW-1:0]    shift_cnt_o,
   output logic             done_o
);

   typedef enum logic {
      ACTIVE    = 1'b0,
      SATURATED = 1'b1
   } state_t;

   localparam logic [1:0]    MODE_HOLD  = 2'b00;
   localparam logic [1:0]    MODE_SHR   = 2'b01;
   localparam logic [1:0]    MODE_SHL   = 2'b10;
   localparam logic [1:0]    MODE_LOAD  = 2'b11;
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;
   logic [WIDTH-1:0] shr_d;
   logic [WIDTH-1:0] shl_d;

   // Serial-in bits are only consumed in their own mode, so unused inputs never reach Q.
   always_comb begin
      shr_d = {sir_i, q_q[WIDTH-1:1]};
      shl_d = {q_q[WIDTH-2:0], sil_i};
`ifdef USR_ROTATE_EN
      if (rot_i) begin
         shr_d = {q_q[0], q_q[WIDTH-1:1]};
         shl_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      end
`endif
   end

`ifndef USR_ROTATE_EN
   logic rot_unused;
   assign rot_unused = rot_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         state_q <= ACTIVE;
      end else begin
         done_q <= 1'b0;
         if (en_i) begin
            case (mode_i)
               MODE_HOLD: ;
               MODE_SHR, MODE_SHL: begin
                  q_q <= (mode_i == MODE_SHR) ? shr_d : shl_d;
                  // Count stops at WIDTH; DONE fires only on the transition into saturation.
                  if (state_q == ACTIVE) begin
                     cnt_q <= cnt_q + 1'b1;
                     if (cnt_q == CNT_LAST) begin
                        state_q <= SATURATED;
                        done_q  <= 1'b1;
                     end
                  end
               end
               MODE_LOAD: begin
                  q_q     <= d_i;
                  cnt_q   <= '0;
                  state_q <= ACTIVE;
               end
               default: ;
            endcase
         end
      end
   end

   assign q_o         = q_q;
   assign sor_o       = q_q[0];
   assign sol_o       = q_q[WIDTH-1];
   assign shift_cnt_o = cnt_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8); expectations follow USR_ROTATE_EN.
module tb_universal_shift_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic       sir;
   logic       sil;
   logic       rot;
   logic [7:0] d;
   logic [7:0] q;
   logic       sor;
   logic       sol;
   logic [3:0] cnt;
   logic       done;

   int tests  = 0;
   int failed = 0;

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .mode_i      (mode),
      .sir_i       (sir),
      .sil_i       (sil),
      .rot_i       (rot),
      .d_i         (d),
      .q_o         (q),
      .sor_o       (sor),
      .sol_o       (sol),
      .shift_cnt_o (cnt),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] val);
      en   = 1'b1;
      mode = 2'b11;
      d    = val;
      step();
   endtask

   initial begin
      logic [7:0] sir_seq;
      logic [7:0] sol_seq;
      sir_seq = 8'b0100_1101; // bit i is applied on shift i: 1,0,1,1,0,0,1,0
      sol_seq = 8'hA5;

      rst_n = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF;
      sir = 1'b0; sil = 1'b0; rot = 1'b0;
      step(); step();
      check("reset_q", q, 8'h00);
      check("reset_cnt", cnt, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      step();
      check("post_reset_load", q, 8'hFF);

      load(8'h00);
      mode = 2'b01;
      for (int i = 0; i < 8; i++) begin
         sir = sir_seq[i];
         step();
         check($sformatf("shr_cnt%0d", i), cnt, i + 1);
         check($sformatf("shr_done%0d", i), done, (i == 7));
      end
      check("shr_q", q, 8'h4D);
      check("shr_sor", sor, 1'b1);
      check("shr_sol", sol, 1'b0);
      mode = 2'b00;
      step();
      check("hold_after_done", done, 0);
      check("hold_q", q, 8'h4D);

      load(8'hA5);
      mode = 2'b10; sil = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("shl_sol%0d", i), sol, sol_seq[7-i]);
         step();
         check($sformatf("shl_done%0d", i), done, (i == 7));
      end
      check("shl_q", q, 8'h00);
      check("shl_cnt", cnt, 8);
      step();
      check("sat_cnt", cnt, 8);
      check("sat_done", done, 0);

      load(8'h3C);
      en = 1'b0; mode = 2'b01; sir = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("en0_q", q, 8'h3C);
      check("en0_cnt", cnt, 0);
      check("en0_done", done, 0);
      en = 1'b1; mode = 2'b00;
      step();
      check("mode00_q", q, 8'h3C);
      check("mode00_cnt", cnt, 0);

      load(8'hF0);
      mode = 2'b01; sir = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("mid_q", q, 8'h07);
      check("mid_cnt", cnt, 5);
      rst_n = 1'b0;
      step();
      check("midrst_q", q, 8'h00);
      check("midrst_cnt", cnt, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("postrst_done%0d", i), done, 0);
      end
      check("postrst_cnt", cnt, 3);

      load(8'h81);
      rot = 1'b1; mode = 2'b10; sil = 1'b0; sir = 1'b0;
      step();
`ifdef USR_ROTATE_EN
      check("rotl_q", q, 8'h03);
`else
      check("rotl_q", q, 8'h02);
`endif
      mode = 2'b01;
      step(); step();
`ifdef USR_ROTATE_EN
      check("rotr_q", q, 8'hC0);
`else
      check("rotr_q", q, 8'h00);
`endif
      check("rot_cnt", cnt, 3);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
